muldiv_hilo: RTL and testbench

Controller that sits directly upstream of the 32-cycle unsigned divider in the EX stage. It accepts DIV/DIVU/MTHI/MTLO operations from the pipeline and handles sign conversion for signed division. It sequences the divider through its start/busy handshake, writes the HI/LO registers, and drives the pipeline stall while the divider is working.

---
 rtl/muldiv_hilo.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_hilo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// HI/LO controller for the EX stage: sequences an external 32-cycle unsigned divider,
// applies sign fix-up for DIV, and handles MTHI/MTLO. Define MULDIV_MULT_EN for MULT/MULTU.
module muldiv_hilo #(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam logic [2:0] OpDiv   = 3'b001;
  localparam logic [2:0] OpDivu  = 3'b010;
  localparam logic [2:0] OpMult  = 3'b011;
  localparam logic [2:0] OpMultu = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  typedef enum logic [2:0] {
    StIdle, StStart, StWait, StFix, StZero, StMStart, StMRun
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        div_start_q, div_start_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] src_q, src_d;

  logic [31:0] rs_mag, rt_mag;
  logic        is_signed;

  assign rs_mag = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign rt_mag = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
  assign is_signed = (op == OpDiv) || (op == OpMult);

`ifdef MULDIV_MULT_EN
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic [5:0]  mcnt_q, mcnt_d;
  logic [32:0] mult_sum;
  logic [63:0] prod_step;
  logic [63:0] prod_fix;

  // Upper half accumulates the multiplicand; the multiplier shifts out of the lower half.
  assign mult_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign prod_step = {mult_sum, prod_q[31:1]};
  assign prod_fix  = q_neg_q ? (~prod_q + 64'd1) : prod_q;
`endif

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    div_start_d = div_start_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    src_d       = src_q;
`ifdef MULDIV_MULT_EN
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    mcnt_d      = mcnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (op_valid) begin
          case (op)
            OpMthi: hi_d = rs_val;
            OpMtlo: lo_d = rs_val;
            OpDiv, OpDivu: begin
              if (rt_val == 32'd0) begin
                src_d   = rs_val;
                state_d = StZero;
              end else begin
                div_a_d     = is_signed ? rs_mag : rs_val;
                div_b_d     = is_signed ? rt_mag : rt_val;
                q_neg_d     = is_signed && (rs_val[31] ^ rt_val[31]);
                r_neg_d     = is_signed && rs_val[31];
                div_start_d = 1'b1;
                state_d     = StStart;
              end
            end
`ifdef MULDIV_MULT_EN
            OpMult, OpMultu: begin
              mcand_d = is_signed ? rs_mag : rs_val;
              prod_d  = {32'd0, (is_signed ? rt_mag : rt_val)};
              q_neg_d = is_signed && (rs_val[31] ^ rt_val[31]);
              mcnt_d  = 6'd0;
              state_d = StMStart;
            end
`endif
            default: ;
          endcase
        end
      end
      StStart: begin
        div_start_d = 1'b0;
        state_d     = StWait;
      end
      StWait: begin
        if (!div_busy) state_d = StFix;
      end
      StFix: begin
        lo_d    = q_neg_q ? (~div_q + 32'd1) : div_q;
        hi_d    = r_neg_q ? (~div_r + 32'd1) : div_r;
        state_d = StIdle;
      end
      StZero: begin
        hi_d    = src_q;
        lo_d    = DIV_ZERO_LO;
        state_d = StIdle;
      end
`ifdef MULDIV_MULT_EN
      StMStart: begin
        prod_d  = prod_step;
        mcnt_d  = 6'd1;
        state_d = StMRun;
      end
      StMRun: begin
        if (mcnt_q == 6'd32) begin
          hi_d    = prod_fix[63:32];
          lo_d    = prod_fix[31:0];
          state_d = StIdle;
        end else begin
          prod_d = prod_step;
          mcnt_d = mcnt_q + 6'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state_q     <= StIdle;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      div_a_q     <= 32'd0;
      div_b_q     <= 32'd0;
      div_start_q <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      src_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      div_start_q <= div_start_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      src_q       <= src_d;
    end
  end

`ifdef MULDIV_MULT_EN
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      mcand_q <= 32'd0;
      prod_q  <= 64'd0;
      mcnt_q  <= 6'd0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      mcnt_q  <= mcnt_d;
    end
  end
`endif

  assign stall     = (state_q != StIdle);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign div_start = div_start_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo with a behavioural 32-cycle divider on the falling edge.
module tb_muldiv_hilo;

  logic        clock = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        stall;
  logic [31:0] hi, lo, div_a, div_b;
  logic        div_start;
  logic        div_busy;
  logic [31:0] div_q, div_r;
  logic [5:0]  dcnt;

  int tests_run = 0;
  int tests_failed = 0;

  muldiv_hilo dut (
    .clock(clock), .resetn(resetn), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .hi(hi), .lo(lo),
    .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_busy(div_busy),
    .div_q(div_q), .div_r(div_r)
  );

  always #5 clock = ~clock;

  // Divider model: samples start on the falling edge, busy for 32 falling edges.
  always @(negedge clock or posedge resetn) begin
    if (resetn) begin
      div_busy <= 1'b0;
      dcnt     <= 6'd0;
      div_q    <= 32'd0;
      div_r    <= 32'd0;
    end else if (div_start && !div_busy) begin
      div_busy <= 1'b1;
      dcnt     <= 6'd31;
      div_q    <= (div_b == 32'd0) ? 32'hFFFFFFFF : div_a / div_b;
      div_r    <= (div_b == 32'd0) ? div_a : div_a % div_b;
    end else if (div_busy) begin
      if (dcnt == 6'd0) div_busy <= 1'b0;
      else dcnt <= dcnt - 6'd1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
  endtask

  task automatic wait_idle(input int max_cycles, output int cycles, output int starts);
    cycles = 0;
    starts = 0;
    for (int k = 1; k <= max_cycles && cycles == 0; k++) begin
      step();
      if (div_start) starts++;
      if (!stall) cycles = k;
    end
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if ({hi, lo, div_a, div_b, div_start, stall} !== 130'd0) begin
      tests_failed++;
      $display("FAIL reset_state: hi=%h lo=%h a=%h b=%h start=%b stall=%b, want all 0",
               hi, lo, div_a, div_b, div_start, stall);
    end
    step();
    step();
    resetn = 1'b0;
    step();
    tests_run++;
    if (stall !== 1'b0 || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_release: stall=%b hi=%h, want 0/0", stall, hi);
    end
  endtask

  task automatic test_mthi_mtlo();
    issue(3'b101, 32'h12345678, 32'h0);
    step();
    tests_run++;
    if (hi !== 32'h12345678 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL mthi: hi=%h stall=%b, want 12345678/0", hi, stall);
    end
    issue(3'b110, 32'hCAFEBABE, 32'h0);
    step();
    op_valid = 1'b0;
    tests_run++;
    if (lo !== 32'hCAFEBABE || hi !== 32'h12345678 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL mtlo: hi=%h lo=%h stall=%b, want 12345678/cafebabe/0", hi, lo, stall);
    end
  endtask

  task automatic test_divu();
    int cyc, st;
    issue(3'b010, 32'd100, 32'd7);
    step();
    op_valid = 1'b0;
    tests_run++;
    if (stall !== 1'b1 || div_start !== 1'b1 || div_a !== 32'd100 || div_b !== 32'd7) begin
      tests_failed++;
      $display("FAIL divu_accept: stall=%b start=%b a=%h b=%h, want 1/1/64/7",
               stall, div_start, div_a, div_b);
    end
    wait_idle(40, cyc, st);
    tests_run++;
    if (cyc !== 34 || st !== 0) begin
      tests_failed++;
      $display("FAIL divu_timing: done at edge %0d, extra starts %0d, want 34/0", cyc, st);
    end
    tests_run++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      tests_failed++;
      $display("FAIL divu_result: lo=%h hi=%h, want e/2", lo, hi);
    end
  endtask

  task automatic test_div_signed();
    int cyc, st;
    issue(3'b001, 32'hFFFFFFF9, 32'd2);
    step();
    op_valid = 1'b0;
    tests_run++;
    if (div_a !== 32'd7 || div_b !== 32'd2) begin
      tests_failed++;
      $display("FAIL div_mag: a=%h b=%h, want 7/2", div_a, div_b);
    end
    wait_idle(40, cyc, st);
    tests_run++;
    if (cyc !== 34 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL div_neg: edge=%0d lo=%h hi=%h, want 34/fffffffd/ffffffff", cyc, lo, hi);
    end
    issue(3'b001, 32'h80000000, 32'hFFFFFFFF);
    step();
    op_valid = 1'b0;
    wait_idle(40, cyc, st);
    tests_run++;
    if (cyc !== 34 || lo !== 32'h80000000 || hi !== 32'h0) begin
      tests_failed++;
      $display("FAIL div_ovf: edge=%0d lo=%h hi=%h, want 34/80000000/0", cyc, lo, hi);
    end
  endtask

  task automatic test_div_zero();
    int st = 0;
    issue(3'b010, 32'd5, 32'd0);
    step();
    op_valid = 1'b0;
    if (div_start) st++;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL divz_stall: stall=%b, want 1", stall);
    end
    step();
    if (div_start) st++;
    step();
    if (div_start) st++;
    tests_run++;
    if (stall !== 1'b0 || hi !== 32'd5 || lo !== 32'hFFFFFFFF || st !== 0) begin
      tests_failed++;
      $display("FAIL divz_result: stall=%b hi=%h lo=%h starts=%0d, want 0/5/ffffffff/0",
               stall, hi, lo, st);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, st;
    issue(3'b010, 32'd50, 32'd6);
    step();
    issue(3'b010, 32'd77, 32'd10);
    wait_idle(40, cyc, st);
    tests_run++;
    if (cyc !== 34 || st !== 0 || lo !== 32'd8 || hi !== 32'd2) begin
      tests_failed++;
      $display("FAIL held_first: edge=%0d starts=%0d lo=%h hi=%h, want 34/0/8/2",
               cyc, st, lo, hi);
    end
    step();
    op_valid = 1'b0;
    tests_run++;
    if (stall !== 1'b1 || div_start !== 1'b1 || div_a !== 32'd77) begin
      tests_failed++;
      $display("FAIL held_accept: stall=%b start=%b a=%h, want 1/1/4d", stall, div_start, div_a);
    end
    wait_idle(40, cyc, st);
    tests_run++;
    if (cyc !== 34 || lo !== 32'd7 || hi !== 32'd7) begin
      tests_failed++;
      $display("FAIL held_second: edge=%0d lo=%h hi=%h, want 34/7/7", cyc, lo, hi);
    end
  endtask

  task automatic test_mult();
    int cyc, st;
    issue(3'b101, 32'h0BADF00D, 32'h0);
    step();
    issue(3'b110, 32'h600DCAFE, 32'h0);
    step();
`ifdef MULDIV_MULT_EN
    issue(3'b011, 32'hFFFFFFFD, 32'd5);
    step();
    op_valid = 1'b0;
    wait_idle(40, cyc, st);
    tests_run++;
    if (cyc !== 33 || st !== 0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      tests_failed++;
      $display("FAIL mult: edge=%0d starts=%0d hi=%h lo=%h, want 33/0/ffffffff/fffffff1",
               cyc, st, hi, lo);
    end
    issue(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    op_valid = 1'b0;
    wait_idle(40, cyc, st);
    tests_run++;
    if (cyc !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      tests_failed++;
      $display("FAIL multu: edge=%0d hi=%h lo=%h, want 33/fffffffe/1", cyc, hi, lo);
    end
    issue(3'b101, 32'h0BADF00D, 32'h0);
    step();
    issue(3'b110, 32'h600DCAFE, 32'h0);
    step();
`else
    issue(3'b011, 32'd3, 32'd5);
    step();
    tests_run++;
    if (stall !== 1'b0 || hi !== 32'h0BADF00D || lo !== 32'h600DCAFE) begin
      tests_failed++;
      $display("FAIL mult_noop: stall=%b hi=%h lo=%h, want 0/0badf00d/600dcafe", stall, hi, lo);
    end
    cyc = 0;
    st = 0;
`endif
    issue(3'b111, 32'h11111111, 32'h22222222);
    step();
    issue(3'b000, 32'h33333333, 32'h44444444);
    step();
    op_valid = 1'b0;
    tests_run++;
    if (stall !== 1'b0 || hi !== 32'h0BADF00D || lo !== 32'h600DCAFE) begin
      tests_failed++;
      $display("FAIL unused_op: stall=%b hi=%h lo=%h, want 0/0badf00d/600dcafe", stall, hi, lo);
    end
  endtask

  task automatic test_mid_reset();
    int cyc, st;
    issue(3'b010, 32'd1000, 32'd3);
    step();
    op_valid = 1'b0;
    repeat (10) step();
    #2;
    resetn = 1'b1;
    #1;
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0 || div_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: hi=%h lo=%h stall=%b start=%b, want 0/0/0/0",
               hi, lo, stall, div_start);
    end
    step();
    resetn = 1'b0;
    step();
    issue(3'b010, 32'd9, 32'd3);
    step();
    op_valid = 1'b0;
    wait_idle(40, cyc, st);
    tests_run++;
    if (cyc !== 34 || lo !== 32'd3 || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL post_reset_divu: edge=%0d lo=%h hi=%h, want 34/3/0", cyc, lo, hi);
    end
  endtask

  initial begin
    resetn   = 1'b1;
    op_valid = 1'b0;
    op       = 3'b000;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    test_reset();
    test_mthi_mtlo();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_back_to_back();
    test_mult();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
